serial_sub_ctrl: RTL and testbench

//  Bit-serial N-bit unsigned subtractor controller: sequences one 1-bit full-subtractor

---
 rtl/sub_pkg.sv | 16 +
 rtl/fs_cell.sv | 41 ++++
 rtl/serial_sub_ctrl.sv | 101 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/fs_cell.sv
// 1-bit full subtractor built from two half subtractors; purely combinational.

// Half subtractor: d = x - y, bo set when y > x.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

// Full subtractor: (a - b) then subtract the incoming borrow; borrows are OR-ed.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1_s;
  logic b1_s;
  logic b2_s;

  half_sub u_hs0 (
    .x  (a),
    .y  (b),
    .d  (d1_s),
    .bo (b1_s)
  );

  half_sub u_hs1 (
    .x  (d1_s),
    .y  (bin),
    .d  (d),
    .bo (b2_s)
  );

  assign bo = b1_s | b2_s;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller: one full-subtractor cell is reused
// over WIDTH cycles, LSB first, to produce diff = a - b and the final borrow.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt_r;

  logic             cell_d_s;
  logic             cell_bo_s;
  logic [WIDTH-1:0] res_next_s;

  fs_cell u_cell (
    .a   (sa_r[0]),
    .b   (sb_r[0]),
    .bin (borrow_r),
    .d   (cell_d_s),
    .bo  (cell_bo_s)
  );

  // New result bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next_s = {cell_d_s, res_r[WIDTH-1:1]};

  // Controller FSM with operand/result shifting and registered busy/done/diff/bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sa_r     <= {WIDTH{1'b0}};
      sb_r     <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // DONE accepts a new request exactly like IDLE for back-to-back operation.
          if (start) begin
            sa_r     <= a;
            sb_r     <= b;
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            state_r  <= ST_RUN;
            busy     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
          res_r    <= res_next_s;
          borrow_r <= cell_bo_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            // Last bit: publish result and final borrow together with the done pulse.
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= res_next_s;
            bout    <= cell_bo_s;
          end else begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl with a reference timing model and a result scoreboard.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int           m_state;
  int           m_cnt;
  logic         m_busy;
  logic         m_done;
  logic [W-1:0] m_diff;
  logic         m_bout;
  logic [W:0]   exp_q[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  // Reference: accept rules, WIDTH-cycle latency, arithmetic result pushed on acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      case (m_state)
        0, 2: begin
          if (start) begin
            exp_q.push_back({(a < b), W'(a - b)});
            m_state <= 1;
            m_cnt   <= 0;
            m_busy  <= 1'b1;
          end else begin
            m_state <= 0;
            m_busy  <= 1'b0;
          end
        end
        1: begin
          if (m_cnt == W - 1) begin
            {m_bout, m_diff} <= exp_q.pop_front();
            m_state <= 2;
            m_busy  <= 1'b0;
            m_done  <= 1'b1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: m_state <= 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("bout", 32'(bout), 32'(m_bout));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic go(input logic [W-1:0] va, input logic [W-1:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    a = '0;
    b = '0;
    tick(10);
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit expired");
  end

  initial begin
    start = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    rst = 1'b0;
    tick(1);

    // basic operation and latency
    go(8'd100, 8'd37);
    chk("t1_diff", 32'(diff), 32'd63);
    chk("t1_bout", 32'(bout), 32'd0);

    // borrow cases
    go(8'd5, 8'd9);
    chk("t2_diff", 32'(diff), 32'd252);
    chk("t2_bout", 32'(bout), 32'd1);
    go(8'd0, 8'd1);
    chk("t2b_diff", 32'(diff), 32'hFF);
    chk("t2b_bout", 32'(bout), 32'd1);

    // equal operands and subtract zero
    go(8'hAA, 8'hAA);
    chk("t3_diff", 32'(diff), 32'd0);
    chk("t3_bout", 32'(bout), 32'd0);
    go(8'hFF, 8'h00);
    chk("t3b_diff", 32'(diff), 32'hFF);
    chk("t3b_bout", 32'(bout), 32'd0);

    // start while busy is ignored
    a = 8'd50; b = 8'd20; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk("t4_diff", 32'(diff), 32'd30);
    chk("t4_bout", 32'(bout), 32'd0);

    // start held high: back-to-back operations every W+1 cycles
    a = 8'd10; b = 8'd3; start = 1'b1;
    tick(3 * (W + 1) + 1);
    start = 1'b0;
    tick(10);
    chk("t5_diff", 32'(diff), 32'd7);

    // reset in the middle of an operation
    a = 8'd200; b = 8'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_diff", 32'(diff), 32'd0);
    chk("t6_bout", 32'(bout), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(12);
    go(8'd9, 8'd4);
    chk("t6b_diff", 32'(diff), 32'd5);
    chk("t6b_bout", 32'(bout), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
